// File: rtl/pcpu_pkg.sv
// Shared PCPU definitions: opcode constants and the imem sequencer FSM encoding.
// Latency: none, this file holds constants and types only.
// Backpressure: none.
package pcpu_pkg;

    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_HALT  = 5'd1;
    localparam logic [4:0] OP_LOAD  = 5'd2;
    localparam logic [4:0] OP_STORE = 5'd3;
    localparam logic [4:0] OP_LDIH  = 5'd4;
    localparam logic [4:0] OP_ADD   = 5'd5;
    localparam logic [4:0] OP_ADDI  = 5'd6;
    localparam logic [4:0] OP_ADDC  = 5'd7;
    localparam logic [4:0] OP_SUB   = 5'd8;
    localparam logic [4:0] OP_SUBI  = 5'd9;
    localparam logic [4:0] OP_SUBC  = 5'd10;
    localparam logic [4:0] OP_CMP   = 5'd11;
    localparam logic [4:0] OP_AND   = 5'd12;
    localparam logic [4:0] OP_OR    = 5'd13;
    localparam logic [4:0] OP_XOR   = 5'd14;
    localparam logic [4:0] OP_SLL   = 5'd15;
    localparam logic [4:0] OP_SRL   = 5'd16;
    localparam logic [4:0] OP_SLA   = 5'd17;
    localparam logic [4:0] OP_SRA   = 5'd18;
    localparam logic [4:0] OP_JUMP  = 5'd19;
    localparam logic [4:0] OP_JMPR  = 5'd20;
    localparam logic [4:0] OP_BZ    = 5'd21;
    localparam logic [4:0] OP_BNZ   = 5'd22;
    localparam logic [4:0] OP_BN    = 5'd23;
    localparam logic [4:0] OP_BNN   = 5'd24;
    localparam logic [4:0] OP_BC    = 5'd25;
    localparam logic [4:0] OP_BNC   = 5'd26;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_RUN   = 3'd3,
        ST_HALT  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/pcpu_imem_sequencer_if.sv
// Loader, control and CPU-facing signals of the imem sequencer.
// Latency: none, wiring only.
// Backpressure: ld_ready throttles the loader; the CPU side has none.
interface pcpu_imem_sequencer_if #(
    parameter int IW = 16,
    parameter int AW = 8,
    parameter int CW = 16
);
    logic          ld_valid;
    logic          ld_ready;
    logic [IW-1:0] ld_data;
    logic          ld_last;
    logic          prog_clr;
    logic          start;
    logic          step_mode;
    logic          step;
    logic [AW-1:0] pc;
    logic [IW-1:0] i_datain;
    logic          cpu_enable;
    logic          cpu_start;
    logic          halted;
    logic [2:0]    state;
    logic [AW:0]   prog_len;
    logic [CW-1:0] instr_count;

    // Loader / test driver / CPU side.
    modport master (
        output ld_valid, ld_data, ld_last, prog_clr, start, step_mode, step, pc,
        input  ld_ready, i_datain, cpu_enable, cpu_start, halted, state,
               prog_len, instr_count
    );

    // Sequencer side.
    modport slave (
        input  ld_valid, ld_data, ld_last, prog_clr, start, step_mode, step, pc,
        output ld_ready, i_datain, cpu_enable, cpu_start, halted, state,
               prog_len, instr_count
    );
endinterface

// File: rtl/pcpu_imem.sv
// Program store: 2^AW x IW RAM, synchronous write, asynchronous read.
// Latency: write lands at the clock edge, visible on rdata right after it.
// Backpressure: none, accepts a write every cycle.
module pcpu_imem #(
    parameter int IW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);
    logic [IW-1:0] mem [2**AW];

    // Contents are deliberately not reset; prog_len gates what is visible.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pcpu_imem_sequencer.sv
// Loads a program over valid/ready, then feeds the CPU from pc with free-run/step and HALT detect.
// Latency: write visible after its edge; start -> RUN/cpu_start/enable next cycle; step -> one enable next cycle.
// Backpressure: ld_ready low outside IDLE/LOAD or when the store is full.
module pcpu_imem_sequencer
    import pcpu_pkg::*;
#(
    parameter int             IW      = 16,
    parameter int             AW      = 8,
    parameter int             OPW     = 5,
    parameter logic [OPW-1:0] HALT_OP = OP_HALT,
    parameter int             CW      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pcpu_imem_sequencer_if.slave bus
);
    localparam logic [AW:0] LAST_ADDR = {1'b0, {AW{1'b1}}};

    seq_state_t    state_q;
    logic [AW:0]   prog_len_q;
    logic [CW-1:0] count_q;
    logic          enable_q;
    logic          start_q;
    logic          halted_q;

    logic          ld_acc;
    logic          en_next;
    logic          is_halt;
    logic [IW-1:0] rd_word;

    // Only IDLE/LOAD take words, and never beyond the top of the store.
    assign bus.ld_ready = ((state_q == ST_IDLE) || (state_q == ST_LOAD)) && !prog_len_q[AW];
    // A clear in the same cycle wins over the handshake, so nothing is written.
    assign ld_acc  = bus.ld_valid && bus.ld_ready && !bus.prog_clr;
    // Free mode enables every cycle; step mode only the cycle after a sampled step.
    assign en_next = !bus.step_mode || bus.step;
    assign is_halt = (bus.i_datain[IW-1 -: OPW] == HALT_OP);

    pcpu_imem #(.IW(IW), .AW(AW)) u_imem (
        .clk   (clk),
        .we    (ld_acc),
        .waddr (prog_len_q[AW-1:0]),
        .wdata (bus.ld_data),
        .raddr (bus.pc),
        .rdata (rd_word)
    );

    // Addresses past the loaded program read as NOP, also hiding stale RAM.
    assign bus.i_datain = ({1'b0, bus.pc} < prog_len_q) ? rd_word : '0;

    // Sequencer FSM with registered CPU controls and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            prog_len_q <= '0;
            count_q    <= '0;
            enable_q   <= 1'b0;
            start_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (bus.prog_clr) begin
                state_q    <= ST_IDLE;
                prog_len_q <= '0;
                count_q    <= '0;
                enable_q   <= 1'b0;
                halted_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (ld_acc) begin
                            prog_len_q <= (AW+1)'(1);
                            state_q    <= (bus.ld_last || prog_len_q == LAST_ADDR) ? ST_READY : ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        if (ld_acc) begin
                            prog_len_q <= prog_len_q + (AW+1)'(1);
                            if (bus.ld_last || prog_len_q == LAST_ADDR) begin
                                state_q <= ST_READY;
                            end
                        end
                    end
                    ST_READY, ST_HALT: begin
                        if (bus.start) begin
                            state_q  <= ST_RUN;
                            start_q  <= 1'b1;
                            halted_q <= 1'b0;
                            count_q  <= '0;
                            enable_q <= en_next;
                        end
                    end
                    ST_RUN: begin
                        if (enable_q && count_q != {CW{1'b1}}) begin
                            count_q <= count_q + CW'(1);
                        end
                        // The HALT fetch itself is an enabled, counted cycle.
                        if (enable_q && is_halt) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                            enable_q <= 1'b0;
                        end else begin
                            enable_q <= en_next;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.state       = state_q;
    assign bus.prog_len    = prog_len_q;
    assign bus.instr_count = count_q;
    assign bus.cpu_enable  = enable_q;
    assign bus.cpu_start   = start_q;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_pcpu_imem_sequencer.sv
// Directed bench for pcpu_imem_sequencer (AW=8 main instance, AW=2 full-store instance).
// Latency: inputs change 1 time unit after a rising edge, outputs checked there too.
// Backpressure: the full-store case streams words with ld_valid held high.
module tb_pcpu_imem_sequencer;
    import pcpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   en_cnt;
    logic [15:0] prog [3];

    always #5 clk = ~clk;

    pcpu_imem_sequencer_if #(.IW(16), .AW(8), .CW(16)) bus ();
    pcpu_imem_sequencer_if #(.IW(16), .AW(2), .CW(16)) bus2 ();

    pcpu_imem_sequencer #(.IW(16), .AW(8), .OPW(5), .HALT_OP(OP_HALT), .CW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pcpu_imem_sequencer #(.IW(16), .AW(2), .OPW(5), .HALT_OP(OP_HALT), .CW(16)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load3();
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = prog[i];
            bus.ld_last  = (i == 2);
            tick();
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    initial begin
        prog[0] = 16'h1100;   // LOAD gr1
        prog[1] = 16'h3101;   // ADDI gr1, 1
        prog[2] = 16'h0800;   // HALT
        reset = 1'b1;
        bus.ld_valid = 0; bus.ld_data = '0; bus.ld_last = 0; bus.prog_clr = 0;
        bus.start = 0; bus.step_mode = 0; bus.step = 0; bus.pc = '0;
        bus2.ld_valid = 0; bus2.ld_data = '0; bus2.ld_last = 0; bus2.prog_clr = 0;
        bus2.start = 0; bus2.step_mode = 0; bus2.step = 0; bus2.pc = '0;
        #1;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("rst_prog_len", 32'(bus.prog_len), 32'd0);
        chk("rst_enable", 32'(bus.cpu_enable), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        tick();
        reset = 1'b0;

        // Start in IDLE is ignored.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("idle_start_ignored", 32'(bus.state), 32'd0);
        chk("idle_no_cpu_start", 32'(bus.cpu_start), 32'd0);

        // Load three words.
        load3();
        chk("load_prog_len", 32'(bus.prog_len), 32'd3);
        chk("load_state_ready", 32'(bus.state), 32'd2);
        chk("ready_ld_ready", 32'(bus.ld_ready), 32'd0);
        bus.pc = 8'd3; #1;
        chk("nop_past_end", 32'(bus.i_datain), 32'h0000);
        bus.pc = 8'd1; #1;
        chk("read_word1", 32'(bus.i_datain), 32'h3101);

        // Free run to HALT.
        bus.pc = 8'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("run_state", 32'(bus.state), 32'd3);
        chk("run_cpu_start", 32'(bus.cpu_start), 32'd1);
        chk("run_enable", 32'(bus.cpu_enable), 32'd1);
        chk("run_count_clr", 32'(bus.instr_count), 32'd0);
        tick();
        chk("cpu_start_one_cycle", 32'(bus.cpu_start), 32'd0);
        bus.pc = 8'd1;
        tick();
        bus.pc = 8'd2;
        chk("not_halted_yet", 32'(bus.halted), 32'd0);
        tick();
        chk("halted", 32'(bus.halted), 32'd1);
        chk("halt_state", 32'(bus.state), 32'd4);
        chk("halt_enable_off", 32'(bus.cpu_enable), 32'd0);
        chk("halt_count", 32'(bus.instr_count), 32'd3);
        tick(); tick();
        chk("halt_count_frozen", 32'(bus.instr_count), 32'd3);

        // Restart from HALT in step mode, pc on a non-HALT word.
        bus.pc = 8'd0;
        bus.step_mode = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("step_restart_state", 32'(bus.state), 32'd3);
        chk("step_restart_halted", 32'(bus.halted), 32'd0);
        chk("step_restart_start", 32'(bus.cpu_start), 32'd1);
        chk("step_no_enable", 32'(bus.cpu_enable), 32'd0);
        chk("step_count_clr", 32'(bus.instr_count), 32'd0);
        en_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            bus.step = 1'b1;
            tick();
            if (bus.cpu_enable) en_cnt++;
            bus.step = 1'b0;
            tick();
            if (bus.cpu_enable) en_cnt++;
            tick();
            if (bus.cpu_enable) en_cnt++;
        end
        chk("step_enabled_cycles", 32'(en_cnt), 32'd3);
        chk("step_count", 32'(bus.instr_count), 32'd3);
        chk("step_no_halt", 32'(bus.halted), 32'd0);

        // Held step: one enable per cycle.
        en_cnt = 0;
        bus.step = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.cpu_enable) en_cnt++;
        end
        bus.step = 1'b0;
        tick();
        chk("held_step_enables", 32'(en_cnt), 32'd4);
        chk("held_step_release", 32'(bus.cpu_enable), 32'd0);
        chk("held_step_count", 32'(bus.instr_count), 32'd7);

        // Back to free mode takes effect next cycle.
        bus.step_mode = 1'b0;
        tick();
        chk("free_mode_enable", 32'(bus.cpu_enable), 32'd1);

        // prog_clr from RUN.
        bus.prog_clr = 1'b1;
        tick();
        bus.prog_clr = 1'b0;
        chk("clr_run_state", 32'(bus.state), 32'd0);
        chk("clr_run_len", 32'(bus.prog_len), 32'd0);
        chk("clr_run_enable", 32'(bus.cpu_enable), 32'd0);
        chk("clr_ld_ready", 32'(bus.ld_ready), 32'd1);
        #1;
        chk("clr_nop", 32'(bus.i_datain), 32'h0000);

        // prog_clr beats start in READY.
        load3();
        chk("reload_ready", 32'(bus.state), 32'd2);
        bus.prog_clr = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.prog_clr = 1'b0;
        bus.start = 1'b0;
        chk("clr_start_state", 32'(bus.state), 32'd0);
        chk("clr_start_len", 32'(bus.prog_len), 32'd0);
        chk("clr_start_no_pulse", 32'(bus.cpu_start), 32'd0);

        // Reset mid-RUN is asynchronous.
        load3();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("pre_reset_run", 32'(bus.state), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_state", 32'(bus.state), 32'd0);
        chk("arst_enable", 32'(bus.cpu_enable), 32'd0);
        chk("arst_len", 32'(bus.prog_len), 32'd0);
        chk("arst_count", 32'(bus.instr_count), 32'd0);
        chk("arst_ld_ready", 32'(bus.ld_ready), 32'd1);
        bus.pc = 8'd1; #1;
        chk("arst_nop", 32'(bus.i_datain), 32'h0000);
        tick();
        reset = 1'b0;

        // AW=2: five words streamed without ld_last, only four accepted.
        for (int i = 0; i < 5; i++) begin
            bus2.ld_valid = 1'b1;
            bus2.ld_data  = 16'hA000 + 16'(i);
            tick();
            if (i == 3) begin
                chk("full_ld_ready", 32'(bus2.ld_ready), 32'd0);
                chk("full_state", 32'(bus2.state), 32'd2);
            end
        end
        bus2.ld_valid = 1'b0;
        chk("full_prog_len", 32'(bus2.prog_len), 32'd4);
        bus2.pc = 2'd3; #1;
        chk("full_last_word", 32'(bus2.i_datain), 32'hA003);
        bus2.pc = 2'd0; #1;
        chk("full_first_word", 32'(bus2.i_datain), 32'hA000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pcpu_imem_sequencer.md
# pcpu_imem_sequencer

Parametrised instruction-memory sequencer for the pipelined CPU. It replaces hand-driven per-cycle instruction stimulus with a loadable program store. A program is streamed in over a valid/ready port, then the CPU is released with start/enable. The block serves `i_datain` from the CPU's `pc`, supports free-run and single-step execution, and detects HALT. It sits between the board/test loader and the PCPU instruction port.

## Interface
Parameters:
- `IW`, 16: instruction width.
- `AW`, 8: PC/address width; store depth is 2^AW.
- `OPW`, 5: opcode field width, taken from `i_datain[IW-1 -: OPW]`.
- `HALT_OP`, 5'b00001: HALT opcode.
- `CW`, 16: instruction-counter width.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ld_valid`  in  1  load word valid.
- `ld_ready`  out  1  load word accepted when `ld_valid & ld_ready`.
- `ld_data`  in  IW  program word.
- `ld_last`  in  1  marks the final word of the program.
- `prog_clr`  in  1  discard the program and return to IDLE.
- `start`  in  1  run request, level-sampled.
- `step_mode`  in  1  1 = single-step.
- `step`  in  1  one-cycle step request.
- `pc`  in  AW  CPU program counter.
- `i_datain`  out  IW  instruction to the CPU.
- `cpu_enable`  out  1  CPU enable.
- `cpu_start`  out  1  one-cycle CPU start pulse.
- `halted`  out  1  HALT fetched.
- `state`  out  3  current FSM state.
- `prog_len`  out  AW+1  number of loaded words.
- `instr_count`  out  CW  enabled cycles in the current run.

## Operation
- States: IDLE, LOAD, READY, RUN, HALT.
- Reset values: state=IDLE; `ld_ready`=1; `cpu_enable`, `cpu_start`, `halted` = 0; `prog_len`=0; `instr_count`=0. RAM contents are not reset.
- `i_datain` = mem[`pc`] when `pc` < `prog_len`, else 16'h0000 (NOP). This is combinational in every state.
- IDLE: `ld_ready`=1. An accepted word is written to mem[0], `prog_len`=1, and the FSM goes to LOAD. If that word also has `ld_last`, the FSM goes to READY instead. `start` is ignored.
- LOAD: each accepted word is written to mem[`prog_len`] and `prog_len` increments. On `ld_last`, or on accepting the word at address 2^AW-1, the FSM goes to READY. `start` is ignored.
- Full store: `ld_ready`=0 whenever `prog_len`=2^AW or the state is not IDLE/LOAD.
- READY: `start`=1 → RUN. `cpu_start` pulses for one cycle on entry to RUN. `instr_count` is cleared.
- RUN, free mode: `cpu_enable`=1 continuously.
- RUN, step mode: `cpu_enable`=1 only in the cycle after a sampled `step`. Each `step` pulse gives exactly one enabled cycle. A `step` held high gives one enabled cycle per cycle.
- `instr_count` increments in every cycle with `cpu_enable`=1 and saturates at 2^CW-1.
- HALT detect: in RUN, in a cycle with `cpu_enable`=1 and opcode(`i_datain`)==HALT_OP, the next state is HALT.
- HALT: `halted`=1, `cpu_enable`=0, and `instr_count` is frozen. `start` → RUN with a new `cpu_start` pulse, `halted`=0, and `instr_count` cleared.
- `prog_clr` from any state → IDLE with `prog_len`=0 next cycle. `prog_clr` has priority over `start`, `step` and load acceptance in the same cycle.
- Toggling `step_mode` mid-run takes effect the next cycle.
- Reset mid-operation returns to the reset values. The old program is lost because `prog_len`=0.

## Timing
- Load throughput: one word per cycle. The write is synchronous, at the clock edge of the handshake.
- A word written at edge N is readable on `i_datain` after edge N.
- `start` sampled at edge N gives state=RUN, `cpu_start`=1 and `cpu_enable`=1 (free mode) during cycle N+1. `cpu_start` is low again in N+2.
- HALT opcode present at edge N with enable high gives `halted`=1 and `cpu_enable`=0 from cycle N+1. The HALT cycle itself is counted.
- `step` sampled at edge N gives `cpu_enable`=1 during cycle N+1 only.

## Structure
- Shared package `pcpu_pkg` holds:
  - the opcode constants (NOP, HALT, LOAD … BNC, 5-bit);
  - the FSM state encoding `seq_state_t` (IDLE=0, LOAD=1, READY=2, RUN=3, HALT=4).
- One sub-module, `pcpu_imem`: 2^AW×IW RAM with a synchronous write port and an asynchronous read port.
- The FSM, counters and NOP masking live in `pcpu_imem_sequencer`.

## Test plan
- Load 3 words {LOAD gr1, ADDI gr1, HALT} with `ld_last` on word 3 → `prog_len`=3, state=READY; `i_datain` at `pc`=3 is 16'h0000.
- READY, pulse `start` → `cpu_start` high exactly 1 cycle. With `pc` driven 0,1,2, `halted` rises the cycle after `pc`=2, `instr_count`=3, `cpu_enable`=0.
- `step_mode`=1, three isolated `step` pulses → exactly 3 enabled cycles; `instr_count`=3 with no HALT reached.
- AW=2, stream 5 words without `ld_last` → 4 accepted, `ld_ready`=0 after the 4th, state=READY, `prog_len`=4.
- `prog_clr` and `start` asserted together in READY → state=IDLE, `prog_len`=0, `cpu_start` stays 0.
- Assert `reset` mid-RUN → all outputs return to reset values asynchronously; `i_datain`=16'h0000 for any `pc`.
